// File: rtl/line_window_buffer_if.sv
// ---------------------------------------------------------------------------
// line_window_buffer_if
// Groups the raster pixel input and the column-triple output of the
// line_window_buffer into one bundle.
//   pix_in / pix_valid        : raster-order source pixel (no backpressure)
//   row_data0/1/2             : pixels from rows r-2, r-1 and r of one column
//   row_valid                 : row_data0..2 form a valid column triple
//   out_col / out_row         : column index and row index r of the triple
//   frame_done                : one-cycle pulse after the last frame pixel
// Modports:
//   master : pixel source / consumer side (drives pix_in, pix_valid)
//   slave  : the buffer itself (drives the triple outputs)
// ---------------------------------------------------------------------------
interface line_window_buffer_if #(
  parameter int COL = 320,
  parameter int ROW = 320,
  parameter int PW  = 24
);
  localparam int CW = (COL > 1) ? $clog2(COL) : 1;
  localparam int RW = (ROW > 1) ? $clog2(ROW) : 1;

  logic [PW-1:0] pix_in;
  logic          pix_valid;
  logic [PW-1:0] row_data0;
  logic [PW-1:0] row_data1;
  logic [PW-1:0] row_data2;
  logic          row_valid;
  logic [CW-1:0] out_col;
  logic [RW-1:0] out_row;
  logic          frame_done;

  modport master (
    output pix_in,
    output pix_valid,
    input  row_data0,
    input  row_data1,
    input  row_data2,
    input  row_valid,
    input  out_col,
    input  out_row,
    input  frame_done
  );

  modport slave (
    input  pix_in,
    input  pix_valid,
    output row_data0,
    output row_data1,
    output row_data2,
    output row_valid,
    output out_col,
    output out_row,
    output frame_done
  );
endinterface

// File: rtl/line_window_buffer.sv
// ---------------------------------------------------------------------------
// line_window_buffer
// Two-line buffer that turns a raster pixel stream into vertical 3-pixel
// column triples (rows r-2, r-1, r) for a downstream 3x3 filter.
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : line_window_buffer_if.slave
//          pix_in/pix_valid in; row_data0..2, row_valid, out_col, out_row,
//          frame_done out (all outputs registered)
// Operation:
//   LB_A holds row r-2, LB_B holds row r-1. Every accepted pixel reads both
//   memories at the write column, then shifts LB_B into LB_A and stores the
//   new pixel into LB_B at that same column. The first two rows of a frame
//   only fill the memories (FILL); rows 2..ROW-1 produce one triple per
//   accepted pixel with one cycle of latency (STREAM). After the last pixel
//   the FSM spends exactly one cycle in DONE, where input is dropped and
//   frame_done is high; that same cycle also carries the final triple.
// ---------------------------------------------------------------------------
module line_window_buffer #(
  parameter int COL = 320,
  parameter int ROW = 320,
  parameter int PW  = 24
) (
  input  logic                clk,
  input  logic                rst,
  line_window_buffer_if.slave bus
);

  localparam int CW = (COL > 1) ? $clog2(COL) : 1;
  localparam int RW = (ROW > 1) ? $clog2(ROW) : 1;

  localparam logic [CW-1:0] COL_LAST  = CW'(COL - 1);
  localparam logic [CW-1:0] COL_ONE   = CW'(1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROW - 1);
  localparam logic [RW-1:0] ROW_ONE   = RW'(1);
  localparam logic [RW-1:0] FILL_LAST = RW'(1);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t state_r;
  state_t state_next_s;

  logic [CW-1:0] wcol_r;
  logic [RW-1:0] wrow_r;

  // Line memories: no reset, FILL rewrites every column before STREAM reads it.
  logic [PW-1:0] lb_a_r [COL];
  logic [PW-1:0] lb_b_r [COL];

  logic          accept_s;
  logic          last_col_s;
  logic          last_row_s;
  logic          fill_row_s;
  logic          emit_s;
  logic [PW-1:0] rd_a_s;
  logic [PW-1:0] rd_b_s;

  logic [PW-1:0] row_data0_r;
  logic [PW-1:0] row_data1_r;
  logic [PW-1:0] row_data2_r;
  logic          row_valid_r;
  logic [CW-1:0] out_col_r;
  logic [RW-1:0] out_row_r;
  logic          frame_done_r;

  // Acceptance and position decode; reset and DONE both discard the pixel.
  always_comb begin
    accept_s   = 1'b0;
    last_col_s = 1'b0;
    last_row_s = 1'b0;
    fill_row_s = 1'b0;
    emit_s     = 1'b0;
    if (bus.pix_valid && !rst && (state_r != ST_DONE)) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    last_col_s = (wcol_r == COL_LAST);
    last_row_s = (wrow_r == ROW_LAST);
    fill_row_s = (wrow_r == FILL_LAST);
    emit_s     = accept_s && (state_r == ST_STREAM);
  end

  // Read ports of both line memories at the current write column.
  always_comb begin
    rd_a_s = lb_a_r[wcol_r];
    rd_b_s = lb_b_r[wcol_r];
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_FILL;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_FILL: begin
        if (accept_s && fill_row_s && last_col_s) begin
          state_next_s = ST_STREAM;
        end else begin
          state_next_s = ST_FILL;
        end
      end
      ST_STREAM: begin
        if (accept_s && last_row_s && last_col_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_STREAM;
        end
      end
      ST_DONE: begin
        state_next_s = ST_FILL;
      end
      default: begin
        state_next_s = ST_FILL;
      end
    endcase
  end

  // Raster position counters; advance only on accepted pixels.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcol_r <= '0;
      wrow_r <= '0;
    end else if (accept_s) begin
      if (last_col_s) begin
        wcol_r <= '0;
        if (last_row_s) begin
          wrow_r <= '0;
        end else begin
          wrow_r <= wrow_r + ROW_ONE;
        end
      end else begin
        wcol_r <= wcol_r + COL_ONE;
        wrow_r <= wrow_r;
      end
    end else begin
      wcol_r <= wcol_r;
      wrow_r <= wrow_r;
    end
  end

  // Line memory update: old LB_B moves up into LB_A, new pixel lands in LB_B.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      lb_a_r[wcol_r] <= rd_b_s;
      lb_b_r[wcol_r] <= bus.pix_in;
    end
  end

  // Registered triple outputs; data/position hold when nothing is emitted.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_data0_r  <= '0;
      row_data1_r  <= '0;
      row_data2_r  <= '0;
      row_valid_r  <= 1'b0;
      out_col_r    <= '0;
      out_row_r    <= '0;
      frame_done_r <= 1'b0;
    end else begin
      row_valid_r  <= emit_s;
      // High exactly while state_r is DONE.
      frame_done_r <= (state_next_s == ST_DONE);
      if (emit_s) begin
        row_data0_r <= rd_a_s;
        row_data1_r <= rd_b_s;
        row_data2_r <= bus.pix_in;
        out_col_r   <= wcol_r;
        out_row_r   <= wrow_r;
      end else begin
        row_data0_r <= row_data0_r;
        row_data1_r <= row_data1_r;
        row_data2_r <= row_data2_r;
        out_col_r   <= out_col_r;
        out_row_r   <= out_row_r;
      end
    end
  end

  assign bus.row_data0  = row_data0_r;
  assign bus.row_data1  = row_data1_r;
  assign bus.row_data2  = row_data2_r;
  assign bus.row_valid  = row_valid_r;
  assign bus.out_col    = out_col_r;
  assign bus.out_row    = out_row_r;
  assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_line_window_buffer.sv
// ---------------------------------------------------------------------------
// tb_line_window_buffer
// Scoreboard bench for line_window_buffer with COL=4, ROW=4, PW=24 and pixel
// value base + 16*row + col. The driver pushes the expected triple (and the
// cycle it must appear in) for every pixel of rows 2..3; the monitor pops
// and compares whenever row_valid or frame_done is seen.
// ---------------------------------------------------------------------------
module tb_line_window_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  line_window_buffer_if #(.COL(4), .ROW(4), .PW(24)) bus ();

  line_window_buffer #(.COL(4), .ROW(4), .PW(24)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] d0;
    logic [23:0] d1;
    logic [23:0] d2;
    int          col;
    int          row;
    bit          fd;
    longint      cyc;
  } exp_t;

  exp_t   sb_q [$];
  exp_t   mon_e;
  int     checks   = 0;
  int     failures = 0;
  int     rv_cnt   = 0;
  int     fd_cnt   = 0;
  longint cycle_cnt = 0;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Monitor: every output event must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.row_valid === 1'b1 || bus.frame_done === 1'b1) begin
      if (bus.row_valid === 1'b1) rv_cnt++;
      if (bus.frame_done === 1'b1) fd_cnt++;
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=rv%0b/fd%0b required=none (t=%0t)",
                 bus.row_valid, bus.frame_done, $time);
      end else begin
        mon_e = sb_q.pop_front();
        chk("row_valid",  64'(bus.row_valid),  64'(1));
        chk("frame_done", 64'(bus.frame_done), 64'(mon_e.fd));
        chk("row_data0",  64'(bus.row_data0),  64'(mon_e.d0));
        chk("row_data1",  64'(bus.row_data1),  64'(mon_e.d1));
        chk("row_data2",  64'(bus.row_data2),  64'(mon_e.d2));
        chk("out_col",    64'(bus.out_col),    64'(mon_e.col));
        chk("out_row",    64'(bus.out_row),    64'(mon_e.row));
        chk("latency",    64'(cycle_cnt),      64'(mon_e.cyc));
      end
    end
  end

  // Sends the first npix pixels of a frame; toggle inserts an idle cycle after each.
  task automatic send_frame(input logic [23:0] base, input bit toggle, input int npix);
    int   r;
    int   c;
    exp_t e;
    for (int i = 0; i < npix; i++) begin
      r = i / 4;
      c = i % 4;
      bus.pix_valid = 1'b1;
      bus.pix_in    = base + 24'(16 * r + c);
      if (r >= 2) begin
        e.d0  = base + 24'(16 * (r - 2) + c);
        e.d1  = base + 24'(16 * (r - 1) + c);
        e.d2  = base + 24'(16 * r + c);
        e.col = c;
        e.row = r;
        e.fd  = (i == 15);
        e.cyc = cycle_cnt + 1;
        sb_q.push_back(e);
      end
      @(posedge clk); #1;
      bus.pix_valid = 1'b0;
      if (toggle) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_row_data0"},  64'(bus.row_data0),  64'(0));
    chk({tag, "_row_data1"},  64'(bus.row_data1),  64'(0));
    chk({tag, "_row_data2"},  64'(bus.row_data2),  64'(0));
    chk({tag, "_row_valid"},  64'(bus.row_valid),  64'(0));
    chk({tag, "_out_col"},    64'(bus.out_col),    64'(0));
    chk({tag, "_out_row"},    64'(bus.out_row),    64'(0));
    chk({tag, "_frame_done"}, 64'(bus.frame_done), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.pix_valid = 1'b0;
    bus.pix_in    = 24'h000000;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_all_zero("reset");

    // Continuous frame, then a pixel held valid during DONE must be dropped.
    send_frame(24'h000000, 1'b0, 16);
    bus.pix_valid = 1'b1;
    bus.pix_in    = 24'h0000EE;
    @(posedge clk); #1;
    bus.pix_valid = 1'b0;
    chk("done_next_row_valid",  64'(bus.row_valid),  64'(0));
    chk("done_next_frame_done", 64'(bus.frame_done), 64'(0));
    chk("done_hold_row_data2",  64'(bus.row_data2),  64'(24'h000033));
    chk("done_hold_out_col",    64'(bus.out_col),    64'(3));
    chk("done_hold_out_row",    64'(bus.out_row),    64'(3));

    // Same frame with pix_valid toggling 1,0,1,0; the trailing idle is DONE.
    send_frame(24'h000000, 1'b1, 16);

    // Partial frame up to pixel 0x22, then reset with a pixel presented.
    send_frame(24'h000000, 1'b0, 11);
    rst           = 1'b1;
    bus.pix_valid = 1'b1;
    bus.pix_in    = 24'h000077;
    @(posedge clk); #1;
    rst           = 1'b0;
    bus.pix_valid = 1'b0;
    chk_all_zero("midreset");
    send_frame(24'h000000, 1'b0, 16);
    @(posedge clk); #1;

    // Back-to-back frames, second one offset by 0x80.
    send_frame(24'h000000, 1'b0, 16);
    @(posedge clk); #1;
    send_frame(24'h000080, 1'b0, 16);

    repeat (4) @(posedge clk);
    #1;
    chk("total_row_valid",   64'(rv_cnt),      64'(43));
    chk("total_frame_done",  64'(fd_cnt),      64'(5));
    chk("scoreboard_drained", 64'(sb_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
